// File: rtl/jtag_bsr_tap_ctrl.sv
// rtl/jtag_bsr_tap_ctrl.sv - IEEE 1149.1-style TAP controller sequencing a BC_2 boundary chain
// Owns the instruction, bypass and IDCODE registers; boundary cells are clocked directly by tck.
module jtag_bsr_tap_ctrl #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int unsigned OPC_EXTEST   = 0,
  parameter int unsigned OPC_SAMPLE   = 1,
  parameter int unsigned OPC_IDCODE   = 2
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  input  logic                bsr_so,
  output logic                bsr_si,
  output logic                bsr_capture_en,
  output logic                bsr_update_en,
  output logic                bsr_shift_dr,
  output logic                bsr_mode,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OPC_EXT  = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] OPC_SMP  = IR_WIDTH'(OPC_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OPC_ID   = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPT  = IR_WIDTH'(1);

  tap_state_t           state, state_nxt;
  logic [IR_WIDTH-1:0]  ir_sr;
  logic                 bypass;
  logic [31:0]          idcode_sr;
  logic                 sel_bsr, sel_id;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= state_nxt;
  end

  assign sel_bsr = (ir_out == OPC_EXT) || (ir_out == OPC_SMP);
  assign sel_id  = (ir_out == OPC_ID);

  always_comb begin
    state_nxt      = state;
    tdo            = 1'b0;
    tdo_en         = 1'b0;
    bsr_capture_en = 1'b1;
    bsr_update_en  = 1'b0;
    bsr_shift_dr   = 1'b0;
    case (state)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
    if (state == SH_IR) begin
      tdo    = ir_sr[0];
      tdo_en = 1'b1;
    end else if (state == SH_DR) begin
      tdo_en       = 1'b1;
      bsr_shift_dr = 1'b1;
      tdo          = sel_bsr ? bsr_so : (sel_id ? idcode_sr[0] : bypass);
    end
    if (sel_bsr && (state == CAP_DR || state == SH_DR)) bsr_capture_en = 1'b0;
    if (sel_bsr && state == UPD_DR)                     bsr_update_en  = 1'b1;
  end

  // Instruction and data registers; only the selected DR captures or shifts.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_out    <= OPC_ID;
      ir_sr     <= '0;
      bypass    <= 1'b0;
      idcode_sr <= IDCODE_VALUE;
    end else begin
      case (state)
        TLR:    if (tms) ir_out <= OPC_ID;
        CAP_IR: ir_sr  <= IR_CAPT;
        SH_IR:  ir_sr  <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_out <= ir_sr;
        CAP_DR: begin
          if (sel_id)                bypass    <= bypass;
          if (sel_id)                idcode_sr <= IDCODE_VALUE;
          else if (!sel_bsr)         bypass    <= 1'b0;
        end
        SH_DR: begin
          if (sel_id)                idcode_sr <= {tdi, idcode_sr[31:1]};
          else if (!sel_bsr)         bypass    <= tdi;
        end
        default: ;
      endcase
    end
  end

  assign bsr_mode  = (ir_out == OPC_EXT);
  assign bsr_si    = tdi;
  assign tap_state = state;

endmodule

// File: tb/tb_jtag_bsr_tap_ctrl.sv
// tb/tb_jtag_bsr_tap_ctrl.sv - directed scoreboard bench for jtag_bsr_tap_ctrl
module tb_jtag_bsr_tap_ctrl;

  localparam logic [31:0] IDV = 32'h1000_0001;

  logic       tck = 1'b0;
  logic       trst_n, tms, tdi, bsr_so;
  logic       tdo, tdo_en, bsr_si, bsr_capture_en, bsr_update_en, bsr_shift_dr, bsr_mode;
  logic [3:0] ir_out, tap_state;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  jtag_bsr_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VALUE(IDV)) dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_so(bsr_so), .bsr_si(bsr_si), .bsr_capture_en(bsr_capture_en),
    .bsr_update_en(bsr_update_en), .bsr_shift_dr(bsr_shift_dr), .bsr_mode(bsr_mode),
    .ir_out(ir_out), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic obs);
    logic e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {31'd0, obs}, {31'd0, e});
    end
  endtask

  task automatic tick(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge tck);
    #1;
  endtask

  // From RTI: load an instruction, checking captured bits optionally; ends in RTI.
  task automatic load_ir(input logic [3:0] val, input bit chk_cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    if (chk_cap) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      if (chk_cap && i < 2) chk_pop("ir_capture_tdo", tdo);
      tick(i == 3, val[i]);
    end
    tick(1, 0); tick(0, 0);
    chk("ir_out_after_upd", {28'd0, ir_out}, {28'd0, val});
  endtask

  task automatic bypass_test(input string tag);
    logic [3:0] pat;
    pat = 4'b1101;
    tick(1, 0); tick(0, 0); tick(0, 0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_pop(tag, tdo);
      tick(0, pat[i]);
      exp_q.push_back(pat[i]);
    end
    chk_pop(tag, tdo);
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  initial begin
    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; bsr_so = 1'b0;
    #12;
    chk("rst_state", {28'd0, tap_state}, 32'hF);
    chk("rst_ir", {28'd0, ir_out}, 32'd2);
    chk("rst_outs", {27'd0, tdo_en, bsr_capture_en, bsr_update_en, bsr_shift_dr, bsr_mode},
        32'b01000);
    trst_n = 1'b1;
    tick(1, 0);
    chk("tlr_hold", {28'd0, tap_state}, 32'hF);

    // TMS walk
    tick(0, 0);
    chk("walk_rti", {28'd0, tap_state}, 32'hC);
    tick(1, 0); chk("walk_seldr", {28'd0, tap_state}, 32'h7);
    tick(0, 0); chk("walk_capdr", {28'd0, tap_state}, 32'h6);
    tick(0, 0); chk("walk_shdr", {28'd0, tap_state}, 32'h2);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("walk_five_ones", {28'd0, tap_state}, 32'hF);

    // IDCODE shift after reset
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("id_tdo_en", {31'd0, tdo_en}, 32'd1);
    chk("id_first_bit", {31'd0, tdo}, 32'd1);
    for (int i = 0; i < 32; i++) exp_q.push_back(IDV[i]);
    for (int i = 0; i < 32; i++) begin
      chk_pop("idcode_bit", tdo);
      tick(i == 31, 1'b0);
    end
    tick(1, 0); tick(0, 0);
    chk("id_back_rti", {28'd0, tap_state}, 32'hC);

    // EXTEST load with IR capture check
    load_ir(4'h0, 1'b1);
    chk("extest_mode", {31'd0, bsr_mode}, 32'd1);

    // BYPASS and an undefined opcode
    load_ir(4'hF, 1'b0);
    bypass_test("bypass_F");
    load_ir(4'h5, 1'b0);
    bypass_test("bypass_5");

    // SAMPLE with a 3-cell chain driven from the bench
    load_ir(4'h1, 1'b0);
    chk("sample_mode", {31'd0, bsr_mode}, 32'd0);
    tick(1, 0); tick(0, 0);
    chk("sample_capdr", {30'd0, bsr_capture_en, bsr_shift_dr}, 32'b00);
    tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      bsr_so = b;
      exp_q.push_back(b);
      #1;
      chk("sample_shdr_ctl", {30'd0, bsr_capture_en, bsr_shift_dr}, 32'b01);
      chk_pop("sample_tdo", tdo);
      tick(i == 2, 1'b1);
    end
    chk("sample_ex1_upd", {31'd0, bsr_update_en}, 32'd0);
    tick(1, 0);
    chk("sample_upd", {30'd0, bsr_update_en, bsr_mode}, 32'b10);
    tick(0, 0);
    chk("sample_upd_gone", {31'd0, bsr_update_en}, 32'd0);

    // Mid-ShDR asynchronous reset under EXTEST
    load_ir(4'h0, 1'b0);
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    chk("pre_rst_capen", {31'd0, bsr_capture_en}, 32'd0);
    #1 trst_n = 1'b0;
    #1;
    chk("async_rst_state", {28'd0, tap_state}, 32'hF);
    chk("async_rst_ir", {28'd0, ir_out}, 32'd2);
    chk("async_rst_ctl", {30'd0, bsr_capture_en, bsr_mode}, 32'b10);
    trst_n = 1'b1;
    tick(1, 0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_bsr_tap_ctrl.md
Name: jtag_bsr_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller that sequences a chain of BC_2-type boundary scan cells and owns the instruction, bypass and IDCODE registers.
- Decodes the instruction and drives the chain's capture/update enables, the shift_dr select and the cell mode.
- Muxes the selected register onto tdo.
- Boundary cells are clocked directly by tck, on both capture_clk and update_clk.

Parameters:
IR_WIDTH, 4, instruction register width; legal range 2 to 8.
IDCODE_VALUE, 32'h1000_0001, device ID; bit 0 must be 1.
OPC_EXTEST, 0, EXTEST opcode.
OPC_SAMPLE, 1, SAMPLE/PRELOAD opcode.
OPC_IDCODE, 2, IDCODE opcode; all-ones is BYPASS.

Ports:
tck  input  1  test clock; all state changes on posedge tck
trst_n  input  1  asynchronous active-low reset
tms  input  1  test mode select, sampled on posedge tck
tdi  input  1  serial data in
tdo  output  1  serial data out
tdo_en  output  1  high in Shift-DR/Shift-IR only
bsr_so  input  1  so of the last boundary cell
bsr_si  output  1  si of the first boundary cell (equals tdi)
bsr_capture_en  output  1  to cell capture_en, active low
bsr_update_en  output  1  to cell update_en, active high
bsr_shift_dr  output  1  to cell shift_dr
bsr_mode  output  1  to cell mode
ir_out  output  IR_WIDTH  current (updated) instruction
tap_state  output  4  FSM state encoding, debug only

Behaviour:
- Reset: trst_n low asynchronously forces Test-Logic-Reset (TLR) and sets ir_out=OPC_IDCODE, bypass=0, idcode_sr=IDCODE_VALUE, ir_sr=0. Outputs are then tdo_en=0, bsr_capture_en=1, bsr_update_en=0, bsr_shift_dr=0, bsr_mode=0.
- TLR with tms=1 held also loads ir_out=OPC_IDCODE on each tck. Five tms=1 clocks reach TLR from any state.
- FSM has the 16 standard states with standard transitions:
  - TLR -0-> RTI; RTI -1-> SelDR; SelDR -0-> CapDR, -1-> SelIR; SelIR -0-> CapIR, -1-> TLR.
  - CapXR -0-> ShXR, -1-> Ex1XR; ShXR -1-> Ex1XR; Ex1XR -0-> PauseXR, -1-> UpdXR.
  - PauseXR -1-> Ex2XR; Ex2XR -0-> ShXR, -1-> UpdXR; UpdXR -0-> RTI, -1-> SelDR.
  - All unlisted arcs self-loop.
- Fixed encoding: TLR=4'hF, RTI=4'hC, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Decode from ir_out: EXTEST and SAMPLE select the BSR, IDCODE selects idcode_sr, and BYPASS plus every undefined opcode selects the bypass register.
- IR actions:
  - CapIR: ir_sr loads {0..., 2'b01}.
  - ShIR: ir_sr shifts right with tdi in at the MSB.
  - UpdIR: ir_out takes ir_sr at the tck edge leaving UpdIR.
- DR actions (selected register only):
  - CapDR: bypass<=0; idcode_sr<=IDCODE_VALUE.
  - ShDR: bypass<=tdi; idcode_sr shifts right with tdi in at the MSB.
- BSR control is combinational from the current state and decode:
  - bsr_capture_en=0 iff BSR selected and state is CapDR or ShDR.
  - bsr_shift_dr=1 iff state is ShDR.
  - bsr_update_en=1 iff BSR selected and state is UpdDR; cells update on the tck edge leaving UpdDR.
  - bsr_mode=1 iff ir_out==OPC_EXTEST.
  - bsr_si=tdi.
- tdo is combinational:
  - ShIR: ir_sr[0].
  - ShDR: selected register LSB; bsr_so for the BSR, bypass for bypass, idcode_sr[0] for IDCODE.
  - Otherwise 0, with tdo_en=0.
- Negedge retiming of tdo is outside this block.
- A new instruction takes effect on the cycle after UpdIR. A mid-shift reset aborts the shift, and ir_out returns to IDCODE without any update pulse.

Test Plan:
- Reset: pulse trst_n low mid-ShDR -> tap_state=F, ir_out=2, bsr_capture_en=1, bsr_mode=0 immediately, with no tck needed.
- TMS walk: from RTI, tms=1,0,0 -> SelDR, CapDR, ShDR (7,6,2). Five tms=1 from any state -> F.
- IDCODE: after reset, go to ShDR and shift 32 bits -> tdo sequence equals IDCODE_VALUE LSB first; first bit is 1.
- IR capture/load: CapIR, then shift in 4'b0000 -> first two tdo bits are 1,0. After UpdIR, ir_out=0 and bsr_mode=1.
- BYPASS: load 4'hF, shift tdi=1,0,1,1 -> tdo=0,1,0,1 (one-cycle delay). Load undefined 4'h5 -> same bypass behaviour.
- SAMPLE: with 3-cell chain, ir_out=1:
  - CapDR -> bsr_capture_en=0, bsr_shift_dr=0.
  - ShDR x3 -> bsr_shift_dr=1, tdo follows bsr_so.
  - UpdDR -> bsr_update_en=1 for exactly 1 cycle, bsr_mode stays 0.
